// File: rtl/dma_responder_pkg.sv
// Shared definitions for the DMA responder: FSM state encoding, transfer
// geometry (beats per transfer, payload/data widths) and the address
// alignment helper used when a start is sampled.
package dma_responder_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } dma_state_e;

    localparam int WORDS     = 12;   // 32-bit beats per transfer
    localparam int BEAT_W    = 32;   // memory port word width
    localparam int PAYLOAD_W = 384;  // WORDS * BEAT_W
    localparam int DATA_W    = 381;  // controller-side data width
    localparam int PAD_W     = PAYLOAD_W - DATA_W;

    localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

    // A byte address is usable only when it is word aligned
    function automatic logic addr_misaligned(input logic [31:0] addr);
        return |(addr[1:0] & ADDR_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/dma_beat_shifter.sv
// 384-bit load/shift register shared by reads and writes.
// Ports:
//   clk_i, reset_i   - clock, synchronous active-high reset
//   load_i           - parallel load of load_data_i (has priority over shift)
//   shift_i          - shift left by one beat, shift_in_i enters at the LSBs
//   word_o           - most significant beat (next write word, MSB first)
//   tail_o           - lower 352 bits, i.e. the beats already assembled that
//                      will sit above the final beat once it arrives
module dma_beat_shifter
    import dma_responder_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          load_i,
    input  logic                          shift_i,
    input  logic [PAYLOAD_W-1:0]          load_data_i,
    input  logic [BEAT_W-1:0]             shift_in_i,
    output logic [BEAT_W-1:0]             word_o,
    output logic [PAYLOAD_W-BEAT_W-1:0]   tail_o
);

    logic [PAYLOAD_W-1:0] shreg_q;
    logic [PAYLOAD_W-1:0] shreg_d;

    // Next-state selection: load, shift one beat, or hold
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = load_data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[PAYLOAD_W-BEAT_W-1:0], shift_in_i};
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Shift register state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shreg_q <= {PAYLOAD_W{1'b0}};
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign word_o = shreg_q[PAYLOAD_W-1 -: BEAT_W];
    assign tail_o = shreg_q[PAYLOAD_W-BEAT_W-1:0];

endmodule

// File: rtl/dma_responder.sv
// Memory-side DMA responder. Serves one read or write request at a time as a
// burst of WORDS 32-bit beats on a req/ack memory port and reports back via
// dma_idle / dma_done / dma_error.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   dma_rx_start/_address/_data        - read request and 381-bit result
//   dma_tx_start/_address/_data        - write request and 381-bit payload
//   dma_done, dma_idle, dma_error      - completion pulse, idle, sticky error
//   mem_req/we/addr/wdata              - beat request towards memory
//   mem_rdata/ack/err                  - beat response from memory
// The 381-bit data is carried MSB aligned in a 384-bit payload whose three
// LSBs are zero; beat 0 carries the payload MSBs.
module dma_responder
    import dma_responder_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dma_rx_start,
    input  logic [31:0]          dma_rx_address,
    output logic [DATA_W-1:0]    dma_rx_data,
    input  logic                 dma_tx_start,
    input  logic [31:0]          dma_tx_address,
    input  logic [DATA_W-1:0]    dma_tx_data,
    output logic                 dma_done,
    output logic                 dma_idle,
    output logic                 dma_error,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [BEAT_W-1:0]    mem_wdata,
    input  logic [BEAT_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    input  logic                 mem_err
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [3:0]        BEAT_LAST = 4'(WORDS - 1);

    dma_state_e          state_q;
    logic [3:0]          beat_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                dma_idle_q;
    logic                dma_done_q;
    logic                dma_error_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [DATA_W-1:0]   dma_rx_data_q;

    logic                     start_any_s;
    logic                     reject_s;
    logic [31:0]              sel_addr_s;
    logic                     sh_load_s;
    logic                     sh_shift_s;
    logic [PAYLOAD_W-1:0]     sh_load_data_s;
    logic [BEAT_W-1:0]        sh_shift_in_s;
    logic [BEAT_W-1:0]        sh_word_s;
    logic [PAYLOAD_W-BEAT_W-1:0] sh_tail_s;
    logic [DATA_W-1:0]        rd_data_s;
    logic                     busy_s;

    // Start decode and shifter control
    always_comb begin
        start_any_s    = dma_rx_start | dma_tx_start;
        busy_s         = (state_q == S_RD) || (state_q == S_WR);
        sel_addr_s     = dma_rx_address;
        sh_load_data_s = {PAYLOAD_W{1'b0}};
        if (dma_tx_start) begin
            sel_addr_s     = dma_tx_address;
            sh_load_data_s = {dma_tx_data, {PAD_W{1'b0}}};
        end else begin
            sel_addr_s     = dma_rx_address;
            sh_load_data_s = {PAYLOAD_W{1'b0}};
        end
        // Simultaneous starts are ambiguous and are rejected outright
        reject_s  = (dma_rx_start & dma_tx_start) | addr_misaligned(sel_addr_s);
        sh_load_s = (state_q == S_IDLE) & start_any_s & ~reject_s;
        // Only good beats advance the payload; an errored beat is discarded
        sh_shift_s = busy_s & mem_ack & ~mem_err;
        if (state_q == S_WR) begin
            sh_shift_in_s = {BEAT_W{1'b0}};
        end else begin
            sh_shift_in_s = mem_rdata;
        end
    end

    dma_beat_shifter u_shifter (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (sh_load_s),
        .shift_i     (sh_shift_s),
        .load_data_i (sh_load_data_s),
        .shift_in_i  (sh_shift_in_s),
        .word_o      (sh_word_s),
        .tail_o      (sh_tail_s)
    );

    // Final read value: assembled beats plus the beat arriving now, pad dropped
    assign rd_data_s = {sh_tail_s, mem_rdata[BEAT_W-1:PAD_W]};

    // Transfer FSM with beat/timeout counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            beat_q        <= 4'd0;
            wait_q        <= {WAIT_W{1'b0}};
            dma_idle_q    <= 1'b1;
            dma_done_q    <= 1'b0;
            dma_error_q   <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
            dma_rx_data_q <= {DATA_W{1'b0}};
        end else begin
            dma_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_any_s) begin
                        dma_idle_q <= 1'b0;
                        beat_q     <= 4'd0;
                        wait_q     <= {WAIT_W{1'b0}};
                        if (reject_s) begin
                            dma_error_q <= 1'b1;
                            dma_done_q  <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            dma_error_q <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= dma_tx_start;
                            mem_addr_q  <= sel_addr_s;
                            state_q     <= dma_tx_start ? S_WR : S_RD;
                        end
                    end else begin
                        dma_idle_q <= 1'b1;
                    end
                end
                S_RD, S_WR: begin
                    if (mem_ack) begin
                        wait_q <= {WAIT_W{1'b0}};
                        if (mem_err) begin
                            mem_req_q   <= 1'b0;
                            mem_we_q    <= 1'b0;
                            dma_error_q <= 1'b1;
                            dma_done_q  <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (beat_q == BEAT_LAST) begin
                            mem_req_q  <= 1'b0;
                            mem_we_q   <= 1'b0;
                            dma_done_q <= 1'b1;
                            state_q    <= S_DONE;
                            if (state_q == S_RD) begin
                                dma_rx_data_q <= rd_data_s;
                            end else begin
                                dma_rx_data_q <= dma_rx_data_q;
                            end
                        end else begin
                            beat_q     <= beat_q + 4'd1;
                            mem_addr_q <= mem_addr_q + 32'd4;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        dma_error_q <= 1'b1;
                        dma_done_q  <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    dma_idle_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    dma_idle_q <= 1'b1;
                    mem_req_q  <= 1'b0;
                    mem_we_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dma_idle    = dma_idle_q;
    assign dma_done    = dma_done_q;
    assign dma_error   = dma_error_q;
    assign dma_rx_data = dma_rx_data_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = sh_word_s;

endmodule

// File: tb/tb_dma_responder.sv
// Directed testbench for dma_responder (TIMEOUT overridden to 4).
module tb_dma_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         dma_rx_start, dma_tx_start;
    logic [31:0]  dma_rx_address, dma_tx_address;
    logic [380:0] dma_rx_data, dma_tx_data;
    logic         dma_done, dma_idle, dma_error;
    logic         mem_req, mem_we, mem_ack, mem_err;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    // memory model controls and state
    int          lat = 1;
    bit          mem_en = 1'b1;
    int          err_beat = -1;
    logic [31:0] rd_words [12];
    bit          model_clr = 1'b0;
    int          cnt = 0, beat_cnt = 0, req_cycles = 0, stab_viol = 0, log_n = 0;
    logic [31:0] log_addr [16];
    logic [31:0] log_data [16];
    logic        log_we   [16];
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
    logic        prev_we = 1'b0;

    // snapshot of the first cycle after a start
    logic        k1_idle, k1_req, k1_err;
    logic [31:0] k1_addr;

    logic [380:0] exp_rd;
    logic [380:0] ones;

    always #5 clk = ~clk;

    dma_responder #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .dma_rx_start(dma_rx_start), .dma_rx_address(dma_rx_address), .dma_rx_data(dma_rx_data),
        .dma_tx_start(dma_tx_start), .dma_tx_address(dma_tx_address), .dma_tx_data(dma_tx_data),
        .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    assign mem_ack   = mem_req && mem_en && (cnt == lat - 1);
    assign mem_err   = mem_ack && (beat_cnt == err_beat);
    assign mem_rdata = (beat_cnt < 12) ? rd_words[beat_cnt] : 32'h0;

    // memory model: ack latency, beat log, request stability tracking
    always @(posedge clk) begin
        if (model_clr) begin
            cnt <= 0; beat_cnt <= 0; req_cycles <= 0; stab_viol <= 0; log_n <= 0;
            prev_pending <= 1'b0;
        end else begin
            if (mem_req === 1'b1) req_cycles <= req_cycles + 1;
            if (mem_req === 1'b1 && prev_pending &&
                (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_we !== prev_we))
                stab_viol <= stab_viol + 1;
            if (mem_req === 1'b1 && mem_ack) begin
                if (log_n < 16) begin
                    log_addr[log_n] <= mem_addr;
                    log_data[log_n] <= mem_wdata;
                    log_we[log_n]   <= mem_we;
                end
                log_n <= log_n + 1;
                beat_cnt <= beat_cnt + 1;
                cnt <= 0;
                prev_pending <= 1'b0;
            end else if (mem_req === 1'b1) begin
                cnt <= cnt + 1;
                prev_pending <= 1'b1;
                prev_addr <= mem_addr; prev_wdata <= mem_wdata; prev_we <= mem_we;
            end else begin
                prev_pending <= 1'b0;
            end
        end
    end

    // Drive one start in cycle N, return at the negedge of the done cycle (N+done_k)
    task automatic run_start(input logic rx, input logic tx, input logic [31:0] addr,
                             input logic [380:0] txd, output int done_k, output logic err_done);
        @(negedge clk);
        dma_rx_start = rx; dma_tx_start = tx;
        dma_rx_address = addr; dma_tx_address = addr; dma_tx_data = txd;
        model_clr = 1'b1;
        done_k = -1; err_done = 1'bx;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            dma_rx_start = 1'b0; dma_tx_start = 1'b0; model_clr = 1'b0;
            if (k == 1) begin
                k1_idle = dma_idle; k1_req = mem_req; k1_err = dma_error; k1_addr = mem_addr;
            end
            if (dma_done === 1'b1) begin
                done_k = k; err_done = dma_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dma_rx_start = 1'b0; dma_tx_start = 1'b0;
        dma_rx_address = 32'h0; dma_tx_address = 32'h0; dma_tx_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (dma_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", dma_idle); end
        checks++; if (dma_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dma_done); end
        checks++; if (dma_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", dma_error); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_req_we got=%b%b exp=00", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", mem_addr, mem_wdata); end
        checks++; if (dma_rx_data !== '0) begin failures++; $display("FAIL reset_rx_data got=%h exp=0", dma_rx_data); end
        reset = 1'b0;
    endtask

    task automatic test_read();
        int dk; logic de;
        for (int i = 0; i < 12; i++) rd_words[i] = 32'h0;
        rd_words[0] = 32'h8000_0000; rd_words[11] = 32'h0000_000F;
        lat = 1; err_beat = -1;
        run_start(1'b1, 1'b0, 32'h1000, '0, dk, de);
        checks++; if (k1_idle !== 1'b0 || k1_req !== 1'b1) begin failures++; $display("FAIL read_n1 idle/req got=%b/%b exp=0/1", k1_idle, k1_req); end
        checks++; if (k1_addr !== 32'h1000) begin failures++; $display("FAIL read_addr0 got=%h exp=00001000", k1_addr); end
        checks++; if (dk !== 13) begin failures++; $display("FAIL read_done_cycle got=%0d exp=13", dk); end
        checks++; if (de !== 1'b0) begin failures++; $display("FAIL read_error got=%b exp=0", de); end
        checks++; if (dma_rx_data !== exp_rd) begin failures++; $display("FAIL read_data got=%h exp=%h", dma_rx_data, exp_rd); end
        @(negedge clk);
        checks++; if (dma_idle !== 1'b1 || dma_done !== 1'b0) begin failures++; $display("FAIL read_n14 idle/done got=%b/%b exp=1/0", dma_idle, dma_done); end
    endtask

    task automatic test_write();
        int dk; logic de;
        logic [31:0] ea, ed;
        lat = 1; err_beat = -1;
        run_start(1'b0, 1'b1, 32'h2000, 381'h1, dk, de);
        checks++; if (dk !== 13 || de !== 1'b0) begin failures++; $display("FAIL write_done got=%0d/%b exp=13/0", dk, de); end
        checks++; if (log_n !== 12) begin failures++; $display("FAIL write_beats got=%0d exp=12", log_n); end
        for (int k = 0; k < 12; k++) begin
            ea = 32'h2000 + 32'(4 * k);
            ed = (k == 11) ? 32'h0000_0008 : 32'h0;
            checks++;
            if (log_addr[k] !== ea || log_data[k] !== ed || log_we[k] !== 1'b1) begin
                failures++;
                $display("FAIL write_beat%0d got=%h/%h/%b exp=%h/%h/1", k, log_addr[k], log_data[k], log_we[k], ea, ed);
            end
        end
    endtask

    task automatic test_latency();
        int dk; logic de;
        for (int i = 0; i < 12; i++) rd_words[i] = 32'hFFFF_FFFF;
        lat = 3; err_beat = -1;
        run_start(1'b1, 1'b0, 32'h6000, '0, dk, de);
        checks++; if (dk !== 37) begin failures++; $display("FAIL lat_done_cycle got=%0d exp=37", dk); end
        checks++; if (stab_viol !== 0) begin failures++; $display("FAIL lat_stable got=%0d exp=0", stab_viol); end
        checks++; if (log_n !== 12 || log_addr[11] !== 32'h602C) begin failures++; $display("FAIL lat_beats got=%0d/%h exp=12/0000602c", log_n, log_addr[11]); end
        checks++; if (dma_rx_data !== ones || de !== 1'b0) begin failures++; $display("FAIL lat_data got=%h/%b exp=%h/0", dma_rx_data, de, ones); end
        lat = 1;
    endtask

    task automatic test_reject();
        int dk; logic de;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) run_start(1'b1, 1'b1, 32'h1000, '0, dk, de);
            else        run_start(1'b1, 1'b0, 32'h1002, '0, dk, de);
            checks++; if (dk !== 1 || de !== 1'b1) begin failures++; $display("FAIL reject%0d_done got=%0d/%b exp=1/1", t, dk, de); end
            @(negedge clk);
            checks++; if (dma_idle !== 1'b1 || dma_done !== 1'b0) begin failures++; $display("FAIL reject%0d_idle got=%b/%b exp=1/0", t, dma_idle, dma_done); end
            checks++; if (req_cycles !== 0) begin failures++; $display("FAIL reject%0d_noreq got=%0d exp=0", t, req_cycles); end
            checks++; if (dma_rx_data !== ones) begin failures++; $display("FAIL reject%0d_rxdata got=%h exp=%h", t, dma_rx_data, ones); end
        end
    endtask

    task automatic test_mem_err();
        int dk; logic de;
        lat = 1; err_beat = 5;
        run_start(1'b1, 1'b0, 32'h3000, '0, dk, de);
        checks++; if (dk !== 7 || de !== 1'b1) begin failures++; $display("FAIL memerr_done got=%0d/%b exp=7/1", dk, de); end
        checks++; if (mem_req !== 1'b0 || log_n !== 6) begin failures++; $display("FAIL memerr_abort got=%b/%0d exp=0/6", mem_req, log_n); end
        checks++; if (dma_rx_data !== ones) begin failures++; $display("FAIL memerr_rxdata got=%h exp=%h", dma_rx_data, ones); end
        err_beat = -1;
        for (int i = 0; i < 12; i++) rd_words[i] = 32'h0;
        rd_words[0] = 32'h8000_0000; rd_words[11] = 32'h0000_000F;
        run_start(1'b1, 1'b0, 32'h3000, '0, dk, de);
        checks++; if (k1_err !== 1'b0) begin failures++; $display("FAIL memerr_clear got=%b exp=0", k1_err); end
        checks++; if (dk !== 13 || de !== 1'b0) begin failures++; $display("FAIL memerr_good got=%0d/%b exp=13/0", dk, de); end
        checks++; if (dma_rx_data !== exp_rd) begin failures++; $display("FAIL memerr_gooddata got=%h exp=%h", dma_rx_data, exp_rd); end
    endtask

    task automatic test_reset_mid();
        int dones;
        lat = 1; err_beat = -1;
        @(negedge clk);
        dma_tx_start = 1'b1; dma_tx_address = 32'h4000; dma_tx_data = ones; model_clr = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            dma_tx_start = 1'b0; model_clr = 1'b0;
        end
        checks++; if (mem_addr !== 32'h4018 || mem_we !== 1'b1) begin failures++; $display("FAIL rstmid_beat6 got=%h/%b exp=00004018/1", mem_addr, mem_we); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (dma_idle !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b/%b/%b exp=1/0/0", dma_idle, mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || dma_rx_data !== '0 || dma_error !== 1'b0) begin failures++; $display("FAIL rstmid_values got=%h/%h/%b exp=0/0/0", mem_addr, mem_wdata, dma_error); end
        dones = (dma_done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (dma_done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_nodone got=%0d exp=0", dones); end
    endtask

    task automatic test_timeout();
        int dk; logic de;
        mem_en = 1'b0;
        run_start(1'b1, 1'b0, 32'h5000, '0, dk, de);
        checks++; if (k1_req !== 1'b1) begin failures++; $display("FAIL timeout_req got=%b exp=1", k1_req); end
        checks++; if (dk !== 5 || de !== 1'b1) begin failures++; $display("FAIL timeout_done got=%0d/%b exp=5/1", dk, de); end
        checks++; if (mem_req !== 1'b0 || dma_rx_data !== '0) begin failures++; $display("FAIL timeout_state got=%b/%h exp=0/0", mem_req, dma_rx_data); end
        mem_en = 1'b1;
    endtask

    initial begin
        exp_rd = '0; exp_rd[380] = 1'b1; exp_rd[0] = 1'b1;
        ones = '1;
        for (int i = 0; i < 12; i++) rd_words[i] = 32'h0;
        test_reset();
        test_read();
        test_write();
        test_latency();
        test_reject();
        test_mem_err();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
